// File: rtl/fetch_unit.sv
`default_nettype none
// ---- fetch_unit: PC-driven instruction fetch with in-order tag queue, decode buffer and redirect flush
// ---- Rev 1.0
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] i_pc_rdata,
  output logic        o_pc_we,
  output logic [63:0] o_pc_wdata,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [63:0] o_imem_req_addr,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [63:0] o_inst_pc,
  output logic [31:0] o_inst_data,
  input  logic        i_redirect_valid,
  input  logic [63:0] i_redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] c_depth = (CW+1)'(DEPTH);
  localparam logic [0:0] c_st_boot = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  logic [0:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_outstanding, r_drop_cnt, r_buf_count;
  logic [PW-1:0] r_tag_wr, r_tag_rd, r_buf_wr, r_buf_rd;
  logic [63:0]   r_tag_mem [DEPTH];
  logic [95:0]   r_buf_mem [DEPTH];

  logic [CW:0] w_occ;
  logic        w_run, w_redirect, w_accept, w_resp, w_drop_resp, w_push, w_pop;
  logic [95:0] w_head;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_occ       = {1'b0, r_outstanding} + {1'b0, r_buf_count};
  assign w_run       = (r_state == c_st_run);
  assign w_redirect  = w_run && i_redirect_valid;
  assign w_accept    = o_imem_req_valid && i_imem_req_ready;
  assign w_resp      = i_imem_resp_valid;
  // A response landing in a redirect cycle is stale by definition, whatever drop_cnt says.
  assign w_drop_resp = w_resp && (w_redirect || (r_drop_cnt != '0));
  assign w_push      = w_resp && !w_drop_resp;
  assign w_pop       = o_inst_valid && i_inst_ready && !w_redirect;
  assign w_head      = r_buf_mem[r_buf_rd];

  assign o_imem_req_addr = i_pc_rdata;
  assign o_inst_valid    = (r_buf_count != '0);
  assign o_inst_pc       = o_inst_valid ? w_head[95:32] : 64'd0;
  assign o_inst_data     = o_inst_valid ? w_head[31:0]  : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_boot;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_st_boot) w_state_nxt = c_st_run;
  end

  always_comb begin
    o_imem_req_valid = 1'b0;
    o_pc_we          = 1'b0;
    o_pc_wdata       = 64'd0;
    if (r_state == c_st_run) begin
      if (i_redirect_valid) begin
        o_pc_we    = 1'b1;
        o_pc_wdata = i_redirect_pc;
      end else begin
        o_imem_req_valid = (w_occ < c_depth);
        if (o_imem_req_valid && i_imem_req_ready) begin
          o_pc_we    = 1'b1;
          o_pc_wdata = i_pc_rdata + 64'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_buf_count   <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_buf_wr      <= '0;
      r_buf_rd      <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_resp);
      if (w_accept) r_tag_wr <= f_inc(r_tag_wr);
      if (w_resp)   r_tag_rd <= f_inc(r_tag_rd);
      // Every request still in flight after this cycle must be discarded on return.
      if (w_redirect)
        r_drop_cnt <= r_outstanding - CW'(w_resp);
      else if (w_resp && (r_drop_cnt != '0))
        r_drop_cnt <= r_drop_cnt - CW'(1);
      if (w_redirect) begin
        r_buf_count <= '0;
        r_buf_wr    <= '0;
        r_buf_rd    <= '0;
      end else begin
        r_buf_count <= r_buf_count + CW'(w_push) - CW'(w_pop);
        if (w_push) r_buf_wr <= f_inc(r_buf_wr);
        if (w_pop)  r_buf_rd <= f_inc(r_buf_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_tag_mem[r_tag_wr] <= i_pc_rdata;
    if (w_push)   r_buf_mem[r_buf_wr] <= {r_tag_mem[r_tag_rd], i_imem_resp_data};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (w_occ <= c_depth);
      assert (!(w_resp && (r_outstanding == '0)));
      assert (!((r_state == c_st_boot) && (i_pc_rdata != RESET_PC)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---- tb_fetch_unit: directed bench with PC-register and in-order memory models
// ---- Rev 1.0
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] i_pc_rdata = RESET_PC;
  logic        o_pc_we;
  logic [63:0] o_pc_wdata;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready = 1'b1;
  logic [63:0] o_imem_req_addr;
  logic        i_imem_resp_valid = 1'b0;
  logic [31:0] i_imem_resp_data = 32'd0;
  logic        o_inst_valid;
  logic        i_inst_ready = 1'b0;
  logic [63:0] o_inst_pc;
  logic [31:0] o_inst_data;
  logic        i_redirect_valid = 1'b0;
  logic [63:0] i_redirect_pc = 64'd0;

  logic        mem_hold = 1'b0;
  logic [63:0] mem_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pc_rdata(i_pc_rdata), .o_pc_we(o_pc_we), .o_pc_wdata(o_pc_wdata),
    .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(i_imem_req_ready),
    .o_imem_req_addr(o_imem_req_addr),
    .i_imem_resp_valid(i_imem_resp_valid), .i_imem_resp_data(i_imem_resp_data),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
    .o_inst_pc(o_inst_pc), .o_inst_data(o_inst_data),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f_data(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0F0F;
  endfunction

  // PC register plus a memory answering one cycle after acceptance (stalled while mem_hold).
  initial begin
    logic        acc, we;
    logic [63:0] a, wd, ra;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mem_q.delete();
        i_imem_resp_valid = 1'b0;
        i_imem_resp_data  = 32'd0;
        i_pc_rdata        = RESET_PC;
      end else begin
        acc = o_imem_req_valid && i_imem_req_ready;
        a   = o_imem_req_addr;
        we  = o_pc_we;
        wd  = o_pc_wdata;
        #1;
        if (we)  i_pc_rdata = wd;
        if (acc) mem_q.push_back(a);
        if (!mem_hold && mem_q.size() > 0) begin
          ra = mem_q.pop_front();
          i_imem_resp_valid = 1'b1;
          i_imem_resp_data  = f_data(ra);
        end else begin
          i_imem_resp_valid = 1'b0;
          i_imem_resp_data  = 32'd0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 64'd0;
    i_inst_ready     = 1'b0;
    i_imem_req_ready = 1'b1;
    mem_hold         = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_pc_we, o_imem_req_valid, o_inst_valid, o_pc_wdata, o_inst_pc, o_inst_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b rv=%b iv=%b wdata=%h ipc=%h idata=%h, expected all zero",
               o_pc_we, o_imem_req_valid, o_inst_valid, o_pc_wdata, o_inst_pc, o_inst_data);
    end
    do_reset();
    #1;
    n_tests++;
    if (o_imem_req_valid !== 1'b0 || o_pc_we !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_idle: rv=%b we=%b, expected 0 0", o_imem_req_valid, o_pc_we);
    end
    @(negedge clk); #1;
    n_tests++;
    if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: rv=%b addr=%h, expected 1 %h", o_imem_req_valid, o_imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_addr, exp_ipc;
    int n_acc, n_inst;
    do_reset();
    i_inst_ready = 1'b1;
    exp_addr = RESET_PC;
    exp_ipc  = RESET_PC;
    n_acc = 0;
    n_inst = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); #1;
      n_tests++;
      if (o_imem_req_valid && i_imem_req_ready) begin
        if (o_imem_req_addr !== exp_addr || o_pc_we !== 1'b1 || o_pc_wdata !== exp_addr + 64'd4) begin
          n_fail++;
          $display("FAIL seq_req: addr=%h we=%b wdata=%h, expected addr=%h we=1 wdata=%h",
                   o_imem_req_addr, o_pc_we, o_pc_wdata, exp_addr, exp_addr + 64'd4);
        end
        exp_addr = exp_addr + 64'd4;
        n_acc++;
      end else if (o_pc_we !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_idle_we: we=%b, expected 0", o_pc_we);
      end
      if (o_inst_valid) begin
        n_tests++;
        if (o_inst_pc !== exp_ipc || o_inst_data !== f_data(exp_ipc)) begin
          n_fail++;
          $display("FAIL seq_inst: pc=%h data=%h, expected pc=%h data=%h",
                   o_inst_pc, o_inst_data, exp_ipc, f_data(exp_ipc));
        end
        exp_ipc = exp_ipc + 64'd4;
        n_inst++;
      end
    end
    n_tests++;
    if (n_acc < 8 || n_inst < 6) begin
      n_fail++;
      $display("FAIL seq_progress: accepts=%0d insts=%0d, expected >=8 and >=6", n_acc, n_inst);
    end
  endtask

  task automatic test_backpressure();
    int n_acc;
    do_reset();
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (o_imem_req_valid && i_imem_req_ready) n_acc++;
    end
    n_tests++;
    if (n_acc != 2 || o_imem_req_valid !== 1'b0 || o_inst_valid !== 1'b1 || o_inst_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL bp_full: accepts=%0d rv=%b iv=%b ipc=%h, expected 2 0 1 %h",
               n_acc, o_imem_req_valid, o_inst_valid, o_inst_pc, RESET_PC);
    end
    @(negedge clk);
    i_inst_ready = 1'b1;
    @(negedge clk);
    i_inst_ready = 1'b0;
    #1;
    n_tests++;
    if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 64'h8000_0008 || o_inst_pc !== 64'h8000_0004) begin
      n_fail++;
      $display("FAIL bp_resume: rv=%b addr=%h ipc=%h, expected 1 80000008 80000004",
               o_imem_req_valid, o_imem_req_addr, o_inst_pc);
    end
  endtask

  task automatic test_redirect_drop();
    logic found;
    do_reset();
    i_inst_ready = 1'b1;
    mem_hold = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (o_imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_inflight: rv=%b, expected 0 with 2 in flight", o_imem_req_valid);
    end
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 64'h8000_1000;
    #1;
    n_tests++;
    if (o_pc_we !== 1'b1 || o_pc_wdata !== 64'h8000_1000 || o_imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_redirect: we=%b wdata=%h rv=%b, expected 1 80001000 0",
               o_pc_we, o_pc_wdata, o_imem_req_valid);
    end
    @(negedge clk);
    i_redirect_valid = 1'b0;
    mem_hold = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clk); #1;
      if (o_inst_valid) begin
        found = 1'b1;
        n_tests++;
        if (o_inst_pc !== 64'h8000_1000 || o_inst_data !== f_data(64'h8000_1000)) begin
          n_fail++;
          $display("FAIL rd_first_inst: pc=%h data=%h, expected 80001000 %h",
                   o_inst_pc, o_inst_data, f_data(64'h8000_1000));
        end
      end
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL rd_timeout: inst_valid=%b after 12 cycles, expected 1", o_inst_valid);
    end
  endtask

  task automatic test_redirect_resp();
    logic found;
    do_reset();
    i_inst_ready = 1'b1;
    repeat (2) @(negedge clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 64'h8000_2000;
    #1;
    n_tests++;
    if (i_imem_resp_valid !== 1'b1 || o_pc_we !== 1'b1 || o_pc_wdata !== 64'h8000_2000 ||
        o_imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_redirect: resp=%b we=%b wdata=%h rv=%b, expected 1 1 80002000 0",
               i_imem_resp_valid, o_pc_we, o_pc_wdata, o_imem_req_valid);
    end
    @(negedge clk);
    i_redirect_valid = 1'b0;
    #1;
    n_tests++;
    if (o_inst_valid !== 1'b0 || o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 64'h8000_2000) begin
      n_fail++;
      $display("FAIL rr_after: iv=%b rv=%b addr=%h, expected 0 1 80002000",
               o_inst_valid, o_imem_req_valid, o_imem_req_addr);
    end
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk); #1;
      if (o_inst_valid) begin
        found = 1'b1;
        n_tests++;
        if (o_inst_pc !== 64'h8000_2000) begin
          n_fail++;
          $display("FAIL rr_first_inst: pc=%h, expected 80002000", o_inst_pc);
        end
      end
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL rr_timeout: inst_valid=%b after 6 cycles, expected 1", o_inst_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    i_inst_ready = 1'b1;
    @(negedge clk);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    i_redirect_valid = 1'b0;
    #1;
    n_tests++;
    if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC ||
        o_pc_we !== 1'b1 || o_pc_wdata !== 64'd0) begin
      n_fail++;
      $display("FAIL wrap_top: rv=%b addr=%h we=%b wdata=%h, expected 1 fffffffffffffffc 1 0",
               o_imem_req_valid, o_imem_req_addr, o_pc_we, o_pc_wdata);
    end
    @(negedge clk); #1;
    n_tests++;
    if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 64'd0 || o_pc_wdata !== 64'd4) begin
      n_fail++;
      $display("FAIL wrap_zero: rv=%b addr=%h wdata=%h, expected 1 0 4",
               o_imem_req_valid, o_imem_req_addr, o_pc_wdata);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (o_inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: iv=%b, expected 1 before reset", o_inst_valid);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_pc_we, o_imem_req_valid, o_inst_valid, o_pc_wdata, o_inst_pc, o_inst_data} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: we=%b rv=%b iv=%b wdata=%h ipc=%h idata=%h, expected all zero",
               o_pc_we, o_imem_req_valid, o_inst_valid, o_pc_wdata, o_inst_pc, o_inst_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== RESET_PC || o_inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_restart: rv=%b addr=%h iv=%b, expected 1 %h 0",
               o_imem_req_valid, o_imem_req_addr, o_inst_valid, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_redirect_resp();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
